// File: rtl/osc_freq_meter.sv
// Gated frequency meter: counts synchronised rising edges of f0 and f1 over a
// GATE_CYCLES window and reports both counts, a faster/slower compare and overflow.
module osc_freq_meter #(
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             f0,
    input  logic             f1,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             f0_gt,
    output logic             f1_gt,
    output logic             ovf,
    output logic             valid,
    output logic             busy
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync0, sync1;
    logic                   prev0, prev1;
    logic                   pulse0, pulse1;

    logic [GATE_W-1:0] gate;
    logic [CNT_W-1:0]  work0, work1;
    logic [CNT_W-1:0]  work0_nxt, work1_nxt;
    logic              ovf_work, ovf_work_nxt;
    logic              start;

    // Synchroniser chains and edge-detect history
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync0 <= '0;
            sync1 <= '0;
            prev0 <= 1'b0;
            prev1 <= 1'b0;
        end else begin
            sync0 <= {sync0[SYNC_STAGES-2:0], f0};
            sync1 <= {sync1[SYNC_STAGES-2:0], f1};
            prev0 <= sync0[SYNC_STAGES-1];
            prev1 <= sync1[SYNC_STAGES-1];
        end
    end

    assign pulse0 = sync0[SYNC_STAGES-1] & ~prev0;
    assign pulse1 = sync1[SYNC_STAGES-1] & ~prev1;

    // Saturating next counts, including the pulse of the current cycle
    always_comb begin
        work0_nxt    = work0;
        work1_nxt    = work1;
        ovf_work_nxt = ovf_work;
        if (pulse0) begin
            if (work0 == CNT_MAX) ovf_work_nxt = 1'b1;
            else                  work0_nxt    = work0 + CNT_W'(1);
        end
        if (pulse1) begin
            if (work1 == CNT_MAX) ovf_work_nxt = 1'b1;
            else                  work1_nxt    = work1 + CNT_W'(1);
        end
    end

    // Next-state logic; dropping en aborts even in the final window cycle
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (en) state_nxt = MEASURE;
            MEASURE: begin
                if (!en)                    state_nxt = IDLE;
                else if (gate == GATE_LAST) state_nxt = REPORT;
            end
            REPORT:  state_nxt = en ? MEASURE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign start = (state_nxt == MEASURE) && (state != MEASURE);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    // Working counters, gate counter and registered result outputs
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            gate     <= '0;
            work0    <= '0;
            work1    <= '0;
            ovf_work <= 1'b0;
            cnt0     <= '0;
            cnt1     <= '0;
            f0_gt    <= 1'b0;
            f1_gt    <= 1'b0;
            ovf      <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            busy  <= (state_nxt == MEASURE);
            valid <= (state_nxt == REPORT);
            if (start) begin
                gate     <= '0;
                work0    <= '0;
                work1    <= '0;
                ovf_work <= 1'b0;
            end else if (state == MEASURE) begin
                gate     <= gate + GATE_W'(1);
                work0    <= work0_nxt;
                work1    <= work1_nxt;
                ovf_work <= ovf_work_nxt;
            end
            if ((state == MEASURE) && (state_nxt == REPORT)) begin
                cnt0  <= work0_nxt;
                cnt1  <= work1_nxt;
                f0_gt <= (work0_nxt > work1_nxt);
                f1_gt <= (work1_nxt > work0_nxt);
                ovf   <= ovf_work_nxt;
            end
        end
    end

endmodule

// File: tb/tb_osc_freq_meter.sv
// Directed bench for osc_freq_meter: a default instance and a small saturating one,
// with expected window results queued at stimulus time and scored on each valid.
module tb_osc_freq_meter;

    logic clk = 1'b0;
    logic clr, en_m, en_s, f0, f1;

    logic [15:0] m_cnt0, m_cnt1;
    logic        m_f0_gt, m_f1_gt, m_ovf, m_valid, m_busy;
    logic [3:0]  s_cnt0, s_cnt1;
    logic        s_f0_gt, s_f1_gt, s_ovf, s_valid, s_busy;

    typedef struct {
        int   lo0, hi0, lo1, hi1;
        logic gt0, gt1, ov;
    } exp_t;

    exp_t qm[$];
    exp_t qs[$];

    int vecs = 0;
    int errs = 0;
    int h0, h1, c0, c1;
    int n, n2;
    logic m_seen, s_seen;

    always #5 clk = ~clk;

    osc_freq_meter dut (
        .clk(clk), .clr(clr), .en(en_m), .f0(f0), .f1(f1),
        .cnt0(m_cnt0), .cnt1(m_cnt1), .f0_gt(m_f0_gt), .f1_gt(m_f1_gt),
        .ovf(m_ovf), .valid(m_valid), .busy(m_busy)
    );

    osc_freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) dut_s (
        .clk(clk), .clr(clr), .en(en_s), .f0(f0), .f1(f1),
        .cnt0(s_cnt0), .cnt1(s_cnt1), .f0_gt(s_f0_gt), .f1_gt(s_f1_gt),
        .ovf(s_ovf), .valid(s_valid), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
        vecs++;
        assert (((obs >= 32'(lo)) && (obs <= 32'(hi))) === 1'b1)
        else begin
            errs++;
            $error("FAIL %s: got %0d want %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic score(input string pfx, input logic [31:0] o0, input logic [31:0] o1,
                         input logic g0, input logic g1, input logic ov, input exp_t e);
        chk_rng({pfx, "_cnt0"}, o0, e.lo0, e.hi0);
        chk_rng({pfx, "_cnt1"}, o1, e.lo1, e.hi1);
        chk({pfx, "_f0_gt"}, 32'(g0), 32'(e.gt0));
        chk({pfx, "_f1_gt"}, 32'(g1), 32'(e.gt1));
        chk({pfx, "_ovf"},   32'(ov), 32'(e.ov));
    endtask

    // One clock: sample and score outputs at the falling edge, then advance the oscillators
    task automatic step();
        exp_t e;
        @(negedge clk);
        m_seen = m_valid;
        s_seen = s_valid;
        if (m_valid) begin
            chk("m_valid_expected", 32'(qm.size() != 0), 32'd1);
            if (qm.size() != 0) begin
                e = qm.pop_front();
                score("m", 32'(m_cnt0), 32'(m_cnt1), m_f0_gt, m_f1_gt, m_ovf, e);
            end
        end
        if (s_valid) begin
            chk("s_valid_expected", 32'(qs.size() != 0), 32'd1);
            if (qs.size() != 0) begin
                e = qs.pop_front();
                score("s", 32'(s_cnt0), 32'(s_cnt1), s_f0_gt, s_f1_gt, s_ovf, e);
            end
        end
        c0++;
        if (c0 >= h0) begin c0 = 0; f0 = ~f0; end
        c1++;
        if (c1 >= h1) begin c1 = 0; f1 = ~f1; end
    endtask

    task automatic resync(input int half0, input int half1);
        h0 = half0; h1 = half1;
        c0 = 0; c1 = 0;
        f0 = 1'b0; f1 = 1'b0;
    endtask

    // Steps until the selected instance pulses valid; cnt is the number of steps taken
    task automatic wait_valid(input string tag, input bit sel, input int budget, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!(sel ? s_seen : m_seen) && cnt < budget);
        chk({tag, "_valid_seen"}, 32'(sel ? s_seen : m_seen), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cnt0"},  32'(m_cnt0),  32'd0);
        chk({tag, "_cnt1"},  32'(m_cnt1),  32'd0);
        chk({tag, "_f0_gt"}, 32'(m_f0_gt), 32'd0);
        chk({tag, "_f1_gt"}, 32'(m_f1_gt), 32'd0);
        chk({tag, "_ovf"},   32'(m_ovf),   32'd0);
        chk({tag, "_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_busy"},  32'(m_busy),  32'd0);
    endtask

    initial begin
        clr = 1'b0; en_m = 1'b0; en_s = 1'b0;
        resync(5, 10);
        repeat (2) @(negedge clk);
        chk_zero("rst");
        clr = 1'b1;
        repeat (20) step();

        // Basic ratio: F0 period 10, F1 period 20
        en_m = 1'b1;
        qm.push_back('{99, 101, 49, 51, 1'b1, 1'b0, 1'b0});
        repeat (500) step();
        chk("t2_busy_mid", 32'(m_busy), 32'd1);
        wait_valid("t2", 1'b0, 600, n2);
        chk("t2_latency", 32'(500 + n2), 32'd1001);
        chk("t2_busy_report", 32'(m_busy), 32'd0);
        en_m = 1'b0;
        repeat (5) step();
        chk("t2_idle_busy", 32'(m_busy), 32'd0);

        // Equal frequencies, in phase
        resync(4, 4);
        repeat (20) step();
        en_m = 1'b1;
        qm.push_back('{125, 125, 125, 125, 1'b0, 1'b0, 1'b0});
        wait_valid("t3", 1'b0, 1100, n);
        chk("t3_latency", 32'(n), 32'd1001);
        en_m = 1'b0;
        repeat (5) step();

        // Abort halfway: no valid, results held
        en_m = 1'b1;
        repeat (500) step();
        chk("t5_busy_mid", 32'(m_busy), 32'd1);
        en_m = 1'b0;
        step();
        chk("t5_busy_after", 32'(m_busy), 32'd0);
        chk("t5_no_valid", 32'(m_valid), 32'd0);
        repeat (1100) step();
        chk("t5_cnt0_held", 32'(m_cnt0), 32'd125);
        chk("t5_cnt1_held", 32'(m_cnt1), 32'd125);
        chk("t5_idle_busy", 32'(m_busy), 32'd0);

        // Saturation on the small instance, then a non-overflowing window
        resync(2, 20);
        repeat (20) step();
        en_s = 1'b1;
        qs.push_back('{15, 15, 2, 3, 1'b1, 1'b0, 1'b1});
        wait_valid("t4a", 1'b1, 200, n);
        chk("t4a_latency", 32'(n), 32'd101);
        en_s = 1'b0;
        repeat (5) step();
        resync(20, 20);
        repeat (50) step();
        en_s = 1'b1;
        qs.push_back('{2, 3, 2, 3, 1'b0, 1'b0, 1'b0});
        wait_valid("t4b", 1'b1, 200, n);
        chk("t4b_latency", 32'(n), 32'd101);
        en_s = 1'b0;
        repeat (5) step();

        // Reset mid-window with the inputs toggling
        resync(5, 10);
        en_m = 1'b1;
        repeat (300) step();
        chk("t1_busy_mid", 32'(m_busy), 32'd1);
        #2 clr = 1'b0;
        #1 chk_zero("t1_async");
        en_m = 1'b0;
        step();
        clr = 1'b1;
        repeat (50) begin
            step();
            chk("t1_busy_idle", 32'(m_busy), 32'd0);
        end

        // Back-to-back windows; F1 speeds up from period 20 to 10 after the first
        resync(8, 10);
        repeat (20) step();
        en_m = 1'b1;
        qm.push_back('{62, 63, 50, 50, 1'b1, 1'b0, 1'b0});
        wait_valid("t6a", 1'b0, 1100, n);
        chk("t6a_latency", 32'(n), 32'd1001);
        h1 = 5;
        qm.push_back('{62, 63, 95, 101, 1'b0, 1'b1, 1'b0});
        qm.push_back('{62, 63, 100, 100, 1'b0, 1'b1, 1'b0});
        wait_valid("t6b", 1'b0, 1100, n);
        chk("t6b_period", 32'(n), 32'd1001);
        wait_valid("t6c", 1'b0, 1100, n);
        chk("t6c_period", 32'(n), 32'd1001);
        en_m = 1'b0;
        repeat (5) step();

        chk("qm_drained", 32'(qm.size()), 32'd0);
        chk("qs_drained", 32'(qs.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/osc_freq_meter.md
Name: osc_freq_meter

Overview:
Downstream stage of the two-output oscillator model. Samples the oscillator outputs F0 and F1 in the CLK domain and counts rising edges of each over a fixed gate window of CLK cycles. After each window it reports both counts, a faster/slower comparison and an overflow flag. Its results drive the mixed-language testbench's checker and display logic.

Parameters:
GATE_CYCLES, 1000, length of the measurement window in CLK cycles; must be at least 2.
CNT_W, 16, width of the edge counters and of CNT0/CNT1.
SYNC_STAGES, 2, number of synchroniser flops on each of F0 and F1; must be at least 2.

Ports:
CLK  input  1  system clock, rising-edge active
CLR  input  1  asynchronous active-low reset
EN  input  1  level: run measurements while high
F0  input  1  oscillator output 0, asynchronous to CLK
F1  input  1  oscillator output 1, asynchronous to CLK
CNT0  output  CNT_W  F0 rising-edge count from the last completed window
CNT1  output  CNT_W  F1 rising-edge count from the last completed window
F0_GT  output  1  CNT0 > CNT1 for the last window
F1_GT  output  1  CNT1 > CNT0 for the last window
OVF  output  1  a counter saturated during the last window
VALID  output  1  one-cycle pulse: new results are on the outputs
BUSY  output  1  high while a window is in progress

Behaviour:
- Reset (CLR=0, asynchronous): FSM goes to IDLE. All outputs, synchroniser flops, edge-detect flops and internal counters are 0.
- Input path:
  - F0 and F1 each pass through SYNC_STAGES flops, then a rising-edge detector (sync output = 1 and previous = 0).
  - Latency from an input edge to the counter increment is SYNC_STAGES+1 cycles.
  - Exact counting requires input high and low phases of at least 2 CLK cycles each. Faster inputs alias; this is out of scope.
- FSM states: IDLE, MEASURE, REPORT.
- IDLE:
  - BUSY=0. Edge pulses are ignored.
  - EN=1 sampled at edge t: enter MEASURE at t+1 and clear the working counters, the gate counter and the sticky overflow flag.
- MEASURE:
  - BUSY=1. Gate counter increments every cycle (width clog2(GATE_CYCLES)).
  - Each edge pulse increments its working counter. A counter at all-ones stays there and sets the sticky overflow flag.
  - Edges in the final window cycle are counted.
  - After exactly GATE_CYCLES MEASURE cycles, go to REPORT.
  - EN=0 in any MEASURE cycle: abort to IDLE next cycle. No VALID is issued; result outputs keep their previous values.
- REPORT (exactly one cycle):
  - On entry, register CNT0/CNT1 from the working counters, F0_GT/F1_GT from their comparison, and OVF from the sticky flag.
  - VALID=1 in this cycle, i.e. GATE_CYCLES+1 cycles after the EN-sampling edge.
  - Result outputs hold until the next REPORT or reset.
- Equal counts: F0_GT=0 and F1_GT=0. F0_GT and F1_GT are never both 1.
- Exit from REPORT:
  - EN=1: go straight to MEASURE with cleared counters. Back-to-back VALID period is GATE_CYCLES+1 cycles.
  - EN=0: go to IDLE.
- BUSY is 0 in REPORT and IDLE.
- Reset mid-window: immediate return to reset state. A new EN is needed to restart.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset check: assert CLR=0 mid-MEASURE with F0/F1 toggling -> all outputs 0 at once; after release with EN=0, BUSY stays 0 and VALID never pulses.
2. Basic ratio (GATE_CYCLES=1000, CNT_W=16): F0 period 10 CLK, F1 period 20 CLK, EN held -> VALID 1001 cycles after EN sampled; CNT0=100±1, CNT1=50±1, F0_GT=1, F1_GT=0, OVF=0.
3. Equal frequencies: F0 and F1 both period 8 CLK, in phase -> CNT0=CNT1=125, F0_GT=0, F1_GT=0.
4. Saturation (CNT_W=4, GATE_CYCLES=100): F0 period 4 CLK, F1 period 40 CLK -> CNT0=15, CNT1=2 or 3, OVF=1, F0_GT=1. The next window with F0 period 40 gives OVF=0.
5. Abort: EN dropped at cycle 500 of a 1000-cycle window -> no VALID, BUSY=0 the next cycle, CNT0/CNT1 unchanged from the prior window.
6. Back-to-back: EN held through 3 windows, F1 period changing 20->10 CLK between windows -> VALID pulses exactly 1001 cycles apart; F1_GT goes 0->1 on the window after the change settles.
